// File: rtl/mmm_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mmm_pkg;

    localparam int XLEN       = 32;
    localparam int MEM_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [XLEN-1:0]       addr;
        logic                  we;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, cyclically.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IW-1:0]    gnt_idx_o,
    output logic             any_gnt_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % N_REQ);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                gnt_oh_o[cand]  = 1'b1;
                gnt_idx_o       = cand;
            end
        end
        any_gnt_o = found;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between N requesters,
// one outstanding transaction, with per-requester response drop on flush.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no transaction; pick an eligible requester and latch its request
// ADDR      | presenting latched request to memory until mem_addr_ready_i
// WAIT_RESP | waiting for response; forward it, or swallow it if dropped
module mem_arbiter
    import mmm_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [N_REQ-1:0]               flush_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ-1:0]               req_we_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata_i,
    output logic [N_REQ-1:0]               resp_valid_o,
    input  logic [N_REQ-1:0]               resp_ready_i,
    output logic [DATA_W-1:0]              resp_data_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic                           mem_we_o,
    output logic [DATA_W-1:0]              mem_wdata_o,
    output logic                           mem_addr_valid_o,
    input  logic                           mem_addr_ready_i,
    input  logic [DATA_W-1:0]              mem_data_i,
    input  logic                           mem_data_valid_i,
    output logic                           mem_data_ready_o,
    output logic                           busy_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic          drop_q, drop_d;
    mem_req_t      req_q, req_d;
    logic          addr_valid_q, addr_valid_d;
    logic          busy_q, busy_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] arb_oh;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic             drop_now;
    logic [IW-1:0]    ptr_adv;

    assign elig     = req_valid_i & ~flush_i;
    assign drop_now = drop_q | flush_i[gnt_q];
    assign ptr_adv  = IW'(rr_next(int'(gnt_q), N_REQ));

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_gnt_o (arb_any)
    );

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        gnt_d            = gnt_q;
        drop_d           = drop_q;
        req_d            = req_q;
        req_ready_o      = '0;
        resp_valid_o     = '0;
        mem_data_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    // Ready is masked while in reset so nothing looks accepted.
                    req_ready_o = rst_n_i ? arb_oh : '0;
                    gnt_d       = arb_idx;
                    req_d.addr  = req_addr_i[arb_idx];
                    req_d.we    = req_we_i[arb_idx];
                    req_d.wdata = req_wdata_i[arb_idx];
                    drop_d      = 1'b0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (flush_i[gnt_q]) begin
                    drop_d = 1'b1;
                end
                if (mem_addr_ready_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (drop_now) begin
                    mem_data_ready_o = 1'b1;
                    drop_d           = 1'b1;
                    if (mem_data_valid_i) begin
                        drop_d  = 1'b0;
                        ptr_d   = ptr_adv;
                        state_d = IDLE;
                    end
                end else begin
                    resp_valid_o[gnt_q] = mem_data_valid_i;
                    mem_data_ready_o    = resp_ready_i[gnt_q];
                    if (mem_data_valid_i && resp_ready_i[gnt_q]) begin
                        ptr_d   = ptr_adv;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        addr_valid_d = (state_d == ADDR);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            drop_q       <= 1'b0;
            req_q        <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            drop_q       <= drop_d;
            req_q        <= req_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr_o       = req_q.addr;
    assign mem_we_o         = req_q.we;
    assign mem_wdata_o      = req_q.wdata;
    assign mem_addr_valid_o = addr_valid_q;
    assign busy_o           = busy_q;
    assign resp_data_o      = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin order, backpressure, flush, reset.
module tb_mem_arbiter;
    import mmm_pkg::*;

    logic                       clk_i;
    logic                       rst_n_i;
    logic [1:0]                 flush_i;
    logic [1:0]                 req_valid_i;
    logic [1:0]                 req_ready_o;
    logic [1:0][XLEN-1:0]       req_addr_i;
    logic [1:0]                 req_we_i;
    logic [1:0][MEM_DATA_W-1:0] req_wdata_i;
    logic [1:0]                 resp_valid_o;
    logic [1:0]                 resp_ready_i;
    logic [MEM_DATA_W-1:0]      resp_data_o;
    logic [XLEN-1:0]            mem_addr_o;
    logic                       mem_we_o;
    logic [MEM_DATA_W-1:0]      mem_wdata_o;
    logic                       mem_addr_valid_o;
    logic                       mem_addr_ready_i;
    logic [MEM_DATA_W-1:0]      mem_data_i;
    logic                       mem_data_valid_i;
    logic                       mem_data_ready_o;
    logic                       busy_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] W1   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    mem_arbiter #(.N_REQ(2), .ADDR_W(XLEN), .DATA_W(MEM_DATA_W)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_we_i         (req_we_i),
        .req_wdata_i      (req_wdata_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_data_o      (resp_data_o),
        .mem_addr_o       (mem_addr_o),
        .mem_we_o         (mem_we_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_addr_valid_o (mem_addr_valid_o),
        .mem_addr_ready_i (mem_addr_ready_i),
        .mem_data_i       (mem_data_i),
        .mem_data_valid_i (mem_data_valid_i),
        .mem_data_ready_o (mem_data_ready_o),
        .busy_o           (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    // Drives one full transaction from an IDLE sample point back to IDLE.
    task automatic run_txn(input logic [1:0] exp_rdy, input logic [31:0] exp_addr,
                           input logic exp_we, input logic [127:0] exp_wdata,
                           input int addr_stall, input int resp_delay, input int resp_stall,
                           input logic [127:0] rdata);
        #1;
        chk("grant", 128'(req_ready_o), 128'(exp_rdy));
        cyc();
        for (int i = 0; i < addr_stall; i++) begin
            mem_addr_ready_i = 1'b0;
            #1;
            chk("addr_stall_valid", 128'(mem_addr_valid_o), 128'd1);
            chk("addr_stall_addr", 128'(mem_addr_o), 128'(exp_addr));
            cyc();
        end
        mem_addr_ready_i = 1'b1;
        #1;
        chk("addr_valid", 128'(mem_addr_valid_o), 128'd1);
        chk("addr", 128'(mem_addr_o), 128'(exp_addr));
        chk("we", 128'(mem_we_o), 128'(exp_we));
        chk("wdata", mem_wdata_o, exp_wdata);
        chk("no_ready_busy", 128'(req_ready_o), 128'd0);
        cyc();
        mem_addr_ready_i = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            mem_data_valid_i = 1'b0;
            #1;
            chk("wait_no_resp", 128'(resp_valid_o), 128'd0);
            chk("wait_addr_valid", 128'(mem_addr_valid_o), 128'd0);
            chk("wait_busy", 128'(busy_o), 128'd1);
            cyc();
        end
        mem_data_valid_i = 1'b1;
        mem_data_i       = rdata;
        for (int i = 0; i < resp_stall; i++) begin
            resp_ready_i = 2'b00;
            #1;
            chk("resp_stall_ready", 128'(mem_data_ready_o), 128'd0);
            chk("resp_stall_valid", 128'(resp_valid_o), 128'(exp_rdy));
            cyc();
        end
        resp_ready_i = exp_rdy;
        #1;
        chk("resp_valid", 128'(resp_valid_o), 128'(exp_rdy));
        chk("resp_data", resp_data_o, rdata);
        chk("mem_data_ready", 128'(mem_data_ready_o), 128'd1);
        cyc();
        mem_data_valid_i = 1'b0;
        resp_ready_i     = 2'b00;
        #1;
        chk("idle_busy", 128'(busy_o), 128'd0);
    endtask

    initial begin
        rst_n_i          = 1'b0;
        flush_i          = '0;
        req_valid_i      = '0;
        req_addr_i       = '0;
        req_we_i         = '0;
        req_wdata_i      = '0;
        resp_ready_i     = '0;
        mem_addr_ready_i = 1'b0;
        mem_data_i       = '0;
        mem_data_valid_i = 1'b0;
        #1;
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_addr_valid", 128'(mem_addr_valid_o), 128'd0);
        chk("rst_req_ready", 128'(req_ready_o), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid_o), 128'd0);
        chk("rst_mem_data_ready", 128'(mem_data_ready_o), 128'd0);
        chk("rst_mem_addr", 128'(mem_addr_o), 128'd0);
        chk("rst_mem_we", 128'(mem_we_o), 128'd0);
        chk("rst_mem_wdata", mem_wdata_o, 128'd0);
        cyc();
        cyc();
        rst_n_i = 1'b1;

        // Single read from requester 0, response two cycles after address accept.
        req_valid_i   = 2'b01;
        req_addr_i[0] = 32'h0000_1000;
        run_txn(2'b01, 32'h0000_1000, 1'b0, 128'd0, 0, 1, 0, D_A5);

        // Both requesters contend; pointer is now 1 so requester 1 goes first.
        req_valid_i    = 2'b11;
        req_addr_i[0]  = 32'h0000_2000;
        req_addr_i[1]  = 32'h0000_3000;
        req_we_i       = 2'b10;
        req_wdata_i[1] = W1;
        run_txn(2'b10, 32'h0000_3000, 1'b1, W1,     0, 0, 0, 128'h0);
        run_txn(2'b01, 32'h0000_2000, 1'b0, 128'd0, 4, 0, 0, 128'hD1);
        run_txn(2'b10, 32'h0000_3000, 1'b1, W1,     0, 0, 3, 128'hD2);
        run_txn(2'b01, 32'h0000_2000, 1'b0, 128'd0, 0, 2, 0, 128'hD3);
        run_txn(2'b10, 32'h0000_3000, 1'b1, W1,     0, 0, 0, 128'hD4);
        run_txn(2'b01, 32'h0000_2000, 1'b0, 128'd0, 0, 0, 0, 128'hD5);

        // Pointer is 1, but flushing requester 1 in IDLE masks it.
        flush_i = 2'b10;
        #1;
        chk("idle_flush_mask", 128'(req_ready_o), 128'b01);
        cyc();
        flush_i          = 2'b00;
        mem_addr_ready_i = 1'b1;
        #1;
        chk("flush_addr_valid", 128'(mem_addr_valid_o), 128'd1);
        cyc();
        mem_addr_ready_i = 1'b0;
        flush_i          = 2'b01;
        #1;
        chk("flush_drop_ready", 128'(mem_data_ready_o), 128'd1);
        chk("flush_drop_valid", 128'(resp_valid_o), 128'd0);
        cyc();
        flush_i = 2'b00;
        #1;
        chk("drop_sticky_ready", 128'(mem_data_ready_o), 128'd1);
        chk("drop_sticky_busy", 128'(busy_o), 128'd1);
        mem_data_valid_i = 1'b1;
        mem_data_i       = 128'hBAD;
        #1;
        chk("drop_resp_valid", 128'(resp_valid_o), 128'd0);
        chk("drop_consume", 128'(mem_data_ready_o), 128'd1);
        cyc();
        mem_data_valid_i = 1'b0;
        #1;
        chk("drop_idle_busy", 128'(busy_o), 128'd0);
        chk("drop_next_grant", 128'(req_ready_o), 128'b10);

        // Requester 1 served; a flush of requester 0 must not disturb it.
        cyc();
        mem_addr_ready_i = 1'b1;
        cyc();
        mem_addr_ready_i = 1'b0;
        flush_i          = 2'b01;
        #1;
        chk("other_flush_ready", 128'(mem_data_ready_o), 128'd0);
        cyc();
        flush_i          = 2'b00;
        mem_data_valid_i = 1'b1;
        mem_data_i       = 128'hCAFE;
        #1;
        chk("other_flush_valid", 128'(resp_valid_o), 128'b10);
        chk("other_flush_hold", 128'(mem_data_ready_o), 128'd0);
        cyc();
        resp_ready_i = 2'b10;
        flush_i      = 2'b10;
        #1;
        chk("coincident_flush_valid", 128'(resp_valid_o), 128'd0);
        chk("coincident_flush_ready", 128'(mem_data_ready_o), 128'd1);
        cyc();
        flush_i          = 2'b00;
        resp_ready_i     = 2'b00;
        mem_data_valid_i = 1'b0;
        #1;
        chk("coincident_idle", 128'(busy_o), 128'd0);
        chk("coincident_next_grant", 128'(req_ready_o), 128'b01);

        // Reset while the request for requester 0 sits in ADDR.
        cyc();
        #1;
        chk("pre_rst_addr_valid", 128'(mem_addr_valid_o), 128'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_addr_valid", 128'(mem_addr_valid_o), 128'd0);
        chk("midrst_busy", 128'(busy_o), 128'd0);
        chk("midrst_req_ready", 128'(req_ready_o), 128'd0);
        chk("midrst_resp_valid", 128'(resp_valid_o), 128'd0);
        chk("midrst_mem_data_ready", 128'(mem_data_ready_o), 128'd0);
        req_valid_i = 2'b10;
        cyc();
        rst_n_i = 1'b1;
        run_txn(2'b10, 32'h0000_3000, 1'b1, W1, 0, 0, 0, 128'hE1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
